// File: rtl/dec_entry_pkg.sv
// Shared types, limits and range helpers for the decimal-entry-to-binary block.
package dec_entry_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int pos_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int neg_max(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/dec_to_bin_entry_if.sv
// Keypad strobes in, committed operand and display echo out.
// Strobes are single-cycle requests with no ready (always accepted); out_valid is a one-cycle pulse with no backpressure.
interface dec_entry_if #(parameter int WIDTH = 6);
  logic             clr;
  logic [3:0]       digit;
  logic             digit_stb;
  logic             neg_stb;
  logic             enter_stb;
  logic [WIDTH-1:0] bin_out;
  logic             out_valid;
  logic             err;
  logic             neg_disp;
  logic [3:0]       tens_disp;
  logic [3:0]       ones_disp;
  logic [1:0]       state_dbg;

  modport master (
    output clr, digit, digit_stb, neg_stb, enter_stb,
    input  bin_out, out_valid, err, neg_disp, tens_disp, ones_disp, state_dbg
  );

  modport slave (
    input  clr, digit, digit_stb, neg_stb, enter_stb,
    output bin_out, out_valid, err, neg_disp, tens_disp, ones_disp, state_dbg
  );
endinterface

// File: rtl/bcd_pair_to_mag.sv
// Combinational two-digit BCD to binary magnitude (0..99) using shift-add times ten.
module bcd_pair_to_mag (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] mag
);
  logic [6:0] tens_w;

  assign tens_w = {3'b000, tens};
  assign mag    = (tens_w << 3) + (tens_w << 1) + {3'b000, ones};
endmodule

// File: rtl/dec_to_bin_entry.sv
// Collects sign plus up to two BCD digits and commits a range-checked two's-complement operand.
import dec_entry_pkg::*;

module dec_to_bin_entry #(
  parameter int WIDTH = 6
) (
  input logic        clk,
  input logic        reset,
  dec_entry_if.slave bus
);
  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_ONE   = ONE;
  localparam logic [1:0] ST_TWO   = TWO;
  localparam logic [1:0] ST_DONE  = DONE;
  localparam int POS_MAX = pos_max(WIDTH);
  localparam int NEG_MAX = neg_max(WIDTH);

  logic [1:0]       state;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             neg;
  logic [6:0]       mag;
  logic [6:0]       neg_mag;
  logic             legal;
  logic             digit_ok;
  logic [WIDTH-1:0] bin_q;
  logic             valid_q;
  logic             err_q;

  bcd_pair_to_mag u_mag (
    .tens (tens),
    .ones (ones),
    .mag  (mag)
  );

  // Commit always judges the registered digits, so a same-cycle digit never leaks in.
  assign neg_mag  = ~mag + 7'd1;
  assign legal    = neg ? (int'(mag) <= NEG_MAX) : (int'(mag) <= POS_MAX);
  assign digit_ok = (bus.digit <= BCD_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_EMPTY;
      tens    <= 4'd0;
      ones    <= 4'd0;
      neg     <= 1'b0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.clr) begin
        state <= ST_EMPTY;
        tens  <= 4'd0;
        ones  <= 4'd0;
        neg   <= 1'b0;
        err_q <= 1'b0;
      end else if (bus.enter_stb) begin
        state <= ST_DONE;
        if (legal) begin
          bin_q   <= neg ? neg_mag[WIDTH-1:0] : mag[WIDTH-1:0];
          valid_q <= 1'b1;
          err_q   <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end else if (bus.digit_stb) begin
        if (!digit_ok) begin
          err_q <= 1'b1;
        end else begin
          case (state)
            ST_EMPTY: begin
              ones  <= bus.digit;
              state <= ST_ONE;
            end
            ST_ONE: begin
              tens  <= ones;
              ones  <= bus.digit;
              state <= ST_TWO;
            end
            ST_DONE: begin
              tens  <= 4'd0;
              ones  <= bus.digit;
              neg   <= 1'b0;
              state <= ST_ONE;
            end
            default: ;
          endcase
        end
      end else if (bus.neg_stb) begin
        // A sign press after a commit starts a fresh negative entry.
        if (state == ST_DONE) begin
          tens  <= 4'd0;
          ones  <= 4'd0;
          neg   <= 1'b1;
          state <= ST_EMPTY;
        end else begin
          neg <= ~neg;
        end
      end
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.out_valid = valid_q;
  assign bus.err       = err_q;
  assign bus.neg_disp  = neg;
  assign bus.tens_disp = tens;
  assign bus.ones_disp = ones;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_dec_to_bin_entry.sv
// Randomized and directed bench with a digit-list reference model and an out_valid scoreboard.
import dec_entry_pkg::*;

module tb_dec_to_bin_entry;
  localparam int W = 6;

  logic clk;
  logic reset;
  int   cyc;
  int   n_pass;
  int   n_total;

  dec_entry_if #(.WIDTH(W)) bus ();

  dec_to_bin_entry #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: the entry is just a list of accepted digits plus flags
  int             m_digits[$];
  bit             m_neg;
  bit             m_done;
  bit             m_err;
  logic [W-1:0]   m_bin;
  logic [W-1:0]   exp_q[$];
  int             exp_cyc_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int entry_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  task automatic model_apply(input bit rst, input bit c, input int d,
                             input bit ds, input bit ns, input bit es);
    int v;
    if (rst) begin
      m_digits.delete();
      m_neg = 0; m_done = 0; m_err = 0; m_bin = '0;
    end else if (c) begin
      m_digits.delete();
      m_neg = 0; m_done = 0; m_err = 0;
    end else if (es) begin
      v = entry_value();
      m_done = 1;
      if ((!m_neg && v <= 2**(W-1) - 1) || (m_neg && v <= 2**(W-1))) begin
        m_bin = m_neg ? W'(-v) : W'(v);
        m_err = 0;
        exp_q.push_back(m_bin);
        exp_cyc_q.push_back(cyc + 1);
      end else begin
        m_err = 1;
      end
    end else if (ds) begin
      if (d > 9) m_err = 1;
      else if (m_done) begin
        m_digits.delete();
        m_digits.push_back(d);
        m_neg = 0; m_done = 0;
      end else if (m_digits.size() < 2) m_digits.push_back(d);
    end else if (ns) begin
      if (m_done) begin
        m_digits.delete();
        m_neg = 1; m_done = 0;
      end else m_neg = !m_neg;
    end
  endtask

  // driver: one clock of stimulus, then compare the registered outputs
  task automatic step(input bit c, input int d, input bit ds, input bit ns,
                      input bit es, input bit rst = 0);
    int exp_tens, exp_ones, exp_state;
    reset         = rst;
    bus.clr       = c;
    bus.digit     = 4'(d);
    bus.digit_stb = ds;
    bus.neg_stb   = ns;
    bus.enter_stb = es;
    model_apply(rst, c, d, ds, ns, es);
    @(posedge clk);
    #1;
    reset = 0; bus.clr = 0; bus.digit_stb = 0; bus.neg_stb = 0; bus.enter_stb = 0;
    exp_tens  = (m_digits.size() == 2) ? m_digits[0] : 0;
    exp_ones  = (m_digits.size() >= 1) ? m_digits[m_digits.size()-1] : 0;
    exp_state = m_done ? int'(DONE) : m_digits.size();
    check("err", int'(bus.err), int'(m_err));
    check("neg_disp", int'(bus.neg_disp), int'(m_neg));
    check("tens_disp", int'(bus.tens_disp), exp_tens);
    check("ones_disp", int'(bus.ones_disp), exp_ones);
    check("bin_out_held", int'(bus.bin_out), int'(m_bin));
    check("state", int'(bus.state_dbg), exp_state);
  endtask

  task automatic dig(input int d); step(0, d, 1, 0, 0); endtask
  task automatic neg_press(); step(0, 0, 0, 1, 0); endtask
  task automatic enter(); step(0, 0, 0, 0, 1); endtask
  task automatic idle(); step(0, 0, 0, 0, 0); endtask

  // monitor: every out_valid pulse must match the oldest expected commit
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("commit_value", int'(bus.bin_out), int'(exp_q.pop_front()));
        check("commit_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1; bus.clr = 0; bus.digit = '0;
    bus.digit_stb = 0; bus.neg_stb = 0; bus.enter_stb = 0;
    m_bin = '0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("reset_out_valid", int'(bus.out_valid), 0);

    // 25 positive
    dig(2); dig(5); enter(); idle();
    // -32 legal, then -33 illegal
    neg_press(); dig(3); dig(2); enter(); idle();
    neg_press(); dig(3); dig(3); enter(); idle();
    // +32 out of range, then clear
    dig(3); dig(2); enter(); step(1, 0, 0, 0, 0); idle();
    // third digit ignored, invalid digit flags err
    dig(1); dig(2); dig(7); dig(10);
    step(1, 0, 0, 0, 0);
    // enter and digit together, then fresh entry from DONE
    dig(4); step(0, 9, 1, 0, 1); idle(); dig(7); enter(); enter(); idle();
    // reset mid-entry, then enter from empty
    neg_press(); neg_press(); dig(9); step(0, 0, 0, 0, 0, 1);
    check("post_reset_out_valid", int'(bus.out_valid), 0);
    enter(); idle();
    // -0 commits zero
    neg_press(); dig(0); enter(); idle();

    // randomized strobes, overlapping strobes resolved by priority
    for (int i = 0; i < 600; i++) begin
      bit c, ds, ns, es, rst;
      int d;
      rst = ($urandom_range(0, 99) < 2);
      c   = ($urandom_range(0, 99) < 4);
      ds  = ($urandom_range(0, 99) < 45);
      ns  = ($urandom_range(0, 99) < 15);
      es  = ($urandom_range(0, 99) < 20);
      d   = ($urandom_range(0, 99) < 8) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      step(c, d, ds, ns, es, rst);
    end

    idle(); idle(); idle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
